perf_event_monitor: RTL and testbench
=====================================

Name: perf_event_monitor

Overview:
- Synthesizable, parametrised pipeline performance monitor; the in-silicon successor to bench-side stall/flush tallying.
- Sits beside the CPU top level. Takes one-bit qualified event strobes from the hazard/flush logic (stall, flush, retire, ...).
- Keeps a free-running cycle counter plus NUM_EVT event counters, with per-channel level/edge mode, saturation and a cycle-limit halt.
- Counters are read back through a request/valid port.

Parameters:
- NUM_EVT, 4, number of event channels (1..15).
- CNT_W, 32, width of every counter (8..64).
- MAX_CYCLES, 30, counted RUN cycles before entering DONE; 0 = unlimited.
- EDGE_MASK, 4'b0000 (NUM_EVT bits), bit k=1: channel k counts rising edges; bit k=0: channel k counts asserted cycles.
- Derived localparam IDX_W = $clog2(NUM_EVT+1).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  run enable; level-sensitive.
- clear_i  in  1  zero all counters and ovf flags, return to IDLE.
- evt_i  in  NUM_EVT  event strobes, sampled each posedge.
- rd_req_i  in  1  readout request.
- rd_idx_i  in  IDX_W  0 = cycle counter; k+1 = event channel k.
- rd_valid_o  out  1  readout data valid (1-cycle pulse).
- rd_data_o  out  CNT_W  readout value.
- ovf_o  out  NUM_EVT+1  sticky saturation flags; bit 0 = cycle counter, bit k+1 = channel k.
- state_o  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- halt_o  out  1  high while in DONE.

Behaviour:
- Reset (rst_i sampled high): state IDLE; all counters 0; ovf_o 0; rd_valid_o 0; rd_data_o 0; halt_o 0; evt_prev 0. rst_i overrides every other input, including mid-RUN.
- Priority at each edge: rst_i > clear_i > state transition/counting.
- IDLE: start_i=1 -> RUN. No counting on the transition edge.
- RUN: on each edge, cycle_cnt += 1 and the enabled channels increment.
  - Level channel: increments when evt_i[k]=1.
  - Edge channel: increments when evt_i[k]=1 and evt_prev[k]=0.
  - start_i=0 -> PAUSE; that edge neither counts events nor advances cycle_cnt.
- PAUSE: counters hold. start_i=1 -> RUN, no counting on that edge.
- Limit: if MAX_CYCLES != 0 and the RUN-edge update makes cycle_cnt == MAX_CYCLES, go to DONE.
  - Events sampled on that final edge are counted.
  - halt_o rises in the cycle after that edge.
- DONE: all counters frozen; start_i ignored. Leave only via clear_i or rst_i.
- clear_i (any state): all counters and ovf_o go to 0; state -> IDLE; events on that edge are discarded.
- evt_prev <= evt_i on every non-reset edge in every state, clear included. An edge channel held high across a PAUSE->RUN resume therefore does not recount.
- Saturation: a counter at all-ones stays at all-ones, and its ovf bit sets and stays set until clear_i or rst_i. Saturating one counter does not affect the others.
- Readout: rd_req_i sampled at edge N -> rd_valid_o=1 and rd_data_o = selected counter's value before edge N's update, both during cycle N+1.
  - Back-to-back requests are allowed every cycle.
  - rd_idx_i > NUM_EVT returns 0, still with rd_valid_o=1.
  - A request coincident with clear_i returns the pre-clear value.
  - With no request, rd_valid_o=0 and rd_data_o holds its last value.
- Width rules: all counters are unsigned CNT_W bits. MAX_CYCLES is compared zero-extended to CNT_W.

Decomposition:
- Shared package perf_mon_pkg holds:
  - state encoding constants (IDLE/RUN/PAUSE/DONE);
  - readout index constant CYCLE_IDX = 0;
  - channel index constants for the CPU hookup: EVT_STALL=0, EVT_FLUSH=1, EVT_RETIRE=2, EVT_BRANCH=3.
- One natural sub-module, sat_counter: CNT_W-wide saturating counter with inc/clear inputs and a sticky ovf output. Instantiate it NUM_EVT+1 times via generate.
- FSM, edge detect and readout mux live in the top module.

Test Plan:
- Reset mid-RUN after 7 counted cycles with evt_i=4'b0011 -> next cycle all counters 0, state_o=0, ovf_o=0, halt_o=0.
- Defaults, start_i held 1, evt_i[0]=1 every cycle, evt_i[1] toggling 1,0,1,0 -> after 30 RUN edges: state_o=3, halt_o=1, cycle=30, ch0=30, ch1=15; values unchanged 5 cycles later.
- EDGE_MASK=4'b0001, evt_i[0] high for 3 cycles, low for 2, high for 4 -> ch0=2; the same pattern with mask 0 gives ch0=7.
- start_i dropped for 5 cycles at cycle 10 with evt_i[1]=1 held -> state_o=2 during the drop; cycle and ch1 frozen; on resume, counting continues with no gap or double count.
- CNT_W=8, MAX_CYCLES=0, evt_i[2]=1 for 300 RUN cycles -> ch2=255, cycle=255, ovf_o bits 0 and 3 set; clear_i -> all 0 and state_o=0.
- rd_req_i every cycle: idx 0, then 2, then 7 (NUM_EVT=4), with clear_i on the third request -> valid pulses on consecutive cycles; data = pre-update values, then 0 for idx 7.

Source files
------------

// File: rtl/perf_event_monitor_pkg.sv
// Shared encodings for the pipeline performance monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Readout index 0 is the cycle counter; event channel k is read at k+1.
    localparam int CYCLE_IDX = 0;

    // Event channel assignment used by the CPU top-level hookup.
    localparam int EVT_STALL  = 0;
    localparam int EVT_FLUSH  = 1;
    localparam int EVT_RETIRE = 2;
    localparam int EVT_BRANCH = 3;

    // Level channels count every asserted cycle; edge channels only a 0->1 transition.
    function automatic logic evt_hit(input logic edge_mode, input logic cur, input logic prev);
        return cur & (~edge_mode | ~prev);
    endfunction

endpackage

// File: rtl/perf_event_monitor_if.sv
// Counter readout port: request with index, answered by a one-cycle valid pulse.
// Latency: 1 cycle request to data. Backpressure: none, a request may be issued every cycle.
interface perf_event_monitor_if #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32
);
    localparam int IDX_W = $clog2(NUM_EVT + 1);

    logic             rd_req_i;
    logic [IDX_W-1:0] rd_idx_i;
    logic             rd_valid_o;
    logic [CNT_W-1:0] rd_data_o;

    modport master (
        output rd_req_i,
        output rd_idx_i,
        input  rd_valid_o,
        input  rd_data_o
    );

    modport slave (
        input  rd_req_i,
        input  rd_idx_i,
        output rd_valid_o,
        output rd_data_o
    );

endinterface

// File: rtl/perf_event_monitor_sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// Latency: count visible the cycle after the increment edge.
// Backpressure: none; increments at all-ones are absorbed and flagged.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic at_max;

    assign at_max = &cnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (inc_i) begin
            // Once saturated the value is pinned; the flag records that an event was lost.
            if (at_max) begin
                ovf_o <= 1'b1;
            end else begin
                cnt_o <= cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: cycle counter plus NUM_EVT event counters with run/pause/limit control.
// Latency: counters update on the sampling edge; readout data one cycle after the request.
// Backpressure: none; events are sampled every edge and readout accepts a request every cycle.
module perf_event_monitor
    import perf_mon_pkg::*;
#(
    parameter int               NUM_EVT    = 4,
    parameter int               CNT_W      = 32,
    parameter int unsigned      MAX_CYCLES = 30,
    parameter logic [NUM_EVT-1:0] EDGE_MASK = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    perf_event_monitor_if.slave rd,
    output logic [NUM_EVT:0]   ovf_o,
    output logic [1:0]         state_o,
    output logic               halt_o
);

    localparam int               IDX_W = $clog2(NUM_EVT + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    state_t             state;
    logic [NUM_EVT-1:0] evt_prev;
    logic [CNT_W-1:0]   cnt [NUM_EVT+1];
    logic [NUM_EVT:0]   inc;
    logic               count_en;
    logic               lim_hit;
    logic [CNT_W-1:0]   rd_sel;

    // Only a RUN edge that stays in RUN counts; the pause and clear edges are dropped.
    assign count_en = (state == ST_RUN) && start_i && !clear_i;

    // A saturated cycle counter wraps to zero here, which can never match a non-zero limit.
    assign lim_hit = (MAX_CYCLES != 0) && ((cnt[CYCLE_IDX] + CNT_W'(1)) == MAX_C);

    always_comb begin
        inc            = '0;
        inc[CYCLE_IDX] = count_en;
        for (int k = 0; k < NUM_EVT; k++) begin
            inc[k+1] = count_en & evt_hit(EDGE_MASK[k], evt_i[k], evt_prev[k]);
        end
    end

    for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc[k]),
            .cnt_o (cnt[k]),
            .ovf_o (ovf_o[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            halt_o <= 1'b0;
        end else if (clear_i) begin
            state  <= ST_IDLE;
            halt_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!start_i) begin
                        state <= ST_PAUSE;
                    end else if (lim_hit) begin
                        state  <= ST_DONE;
                        halt_o <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_i) state <= ST_RUN;
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

    assign state_o = state;

    // Tracked through pause and clear so a channel held high across a resume is not recounted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_prev <= '0;
        end else begin
            evt_prev <= evt_i;
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (rd.rd_idx_i == IDX_W'(k)) rd_sel = cnt[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd.rd_valid_o <= 1'b0;
            rd.rd_data_o  <= '0;
        end else begin
            rd.rd_valid_o <= rd.rd_req_i;
            if (rd.rd_req_i) rd.rd_data_o <= rd_sel;
        end
    end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Three monitor configurations driven by shared stimulus and checked against a reference model.
module tb_perf_event_monitor;

    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst, start, clear, rd_req;
    logic [NE-1:0] evt;
    logic [2:0]    rd_idx;

    always #5 clk = ~clk;

    perf_event_monitor_if #(.NUM_EVT(NE), .CNT_W(32)) if_a ();
    perf_event_monitor_if #(.NUM_EVT(NE), .CNT_W(32)) if_b ();
    perf_event_monitor_if #(.NUM_EVT(NE), .CNT_W(8))  if_c ();

    assign if_a.rd_req_i = rd_req;
    assign if_a.rd_idx_i = rd_idx;
    assign if_b.rd_req_i = rd_req;
    assign if_b.rd_idx_i = rd_idx;
    assign if_c.rd_req_i = rd_req;
    assign if_c.rd_idx_i = rd_idx;

    logic [NE:0] ovf_a, ovf_b, ovf_c;
    logic [1:0]  st_a, st_b, st_c;
    logic        halt_a, halt_b, halt_c;

    perf_event_monitor #(.NUM_EVT(NE), .CNT_W(32), .MAX_CYCLES(30), .EDGE_MASK(4'b0000)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .rd(if_a), .ovf_o(ovf_a), .state_o(st_a), .halt_o(halt_a));

    perf_event_monitor #(.NUM_EVT(NE), .CNT_W(32), .MAX_CYCLES(0), .EDGE_MASK(4'b0001)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .rd(if_b), .ovf_o(ovf_b), .state_o(st_b), .halt_o(halt_b));

    perf_event_monitor #(.NUM_EVT(NE), .CNT_W(8), .MAX_CYCLES(0), .EDGE_MASK(4'b0000)) dut_c (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .rd(if_c), .ovf_o(ovf_c), .state_o(st_c), .halt_o(halt_c));

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    // Reference model: configuration per instance, state named by plain numbers 0..3.
    int unsigned     m_w    [3] = '{32, 32, 8};
    int unsigned     m_max  [3] = '{30, 0, 0};
    logic [NE-1:0]   m_mask [3] = '{4'b0000, 4'b0001, 4'b0000};
    longint unsigned m_cnt  [3][NE+1];
    logic [NE:0]     m_ovf  [3];
    int              m_st   [3];
    logic [NE-1:0]   m_prev [3];
    logic            m_vld  [3];
    longint unsigned m_dat  [3];

    function automatic void bump(input int d, input int i);
        longint unsigned top = (64'd1 << m_w[d]) - 64'd1;
        if (m_cnt[d][i] == top) m_ovf[d][i] = 1'b1;
        else m_cnt[d][i] = m_cnt[d][i] + 1;
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int i = 0; i <= NE; i++) m_cnt[d][i] = 0;
                m_ovf[d] = '0; m_st[d] = 0; m_prev[d] = '0; m_vld[d] = 1'b0; m_dat[d] = 0;
                continue;
            end
            m_vld[d] = rd_req;
            if (rd_req) m_dat[d] = (rd_idx <= NE) ? m_cnt[d][rd_idx] : 64'd0;
            if (clear) begin
                for (int i = 0; i <= NE; i++) m_cnt[d][i] = 0;
                m_ovf[d] = '0;
                m_st[d]  = 0;
            end else begin
                case (m_st[d])
                    0: if (start) m_st[d] = 1;
                    1: begin
                        if (!start) m_st[d] = 2;
                        else begin
                            bump(d, 0);
                            for (int k = 0; k < NE; k++)
                                if (evt[k] && !(m_mask[d][k] && m_prev[d][k])) bump(d, k + 1);
                            if (m_max[d] != 0 && m_cnt[d][0] == 64'(m_max[d])) m_st[d] = 3;
                        end
                    end
                    2: if (start) m_st[d] = 1;
                    default: ;
                endcase
            end
            m_prev[d] = evt;
        end
    endfunction

    task automatic cmp_dut(input int d, input logic [1:0] st, input logic hl, input logic [NE:0] ov,
                           input logic vld, input longint unsigned dat);
        chk($sformatf("d%0d state", d), st, m_st[d]);
        chk($sformatf("d%0d halt", d), hl, (m_st[d] == 3));
        chk($sformatf("d%0d ovf", d), ov, m_ovf[d]);
        chk($sformatf("d%0d rd_valid", d), vld, m_vld[d]);
        chk($sformatf("d%0d rd_data", d), dat, m_dat[d]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_dut(0, st_a, halt_a, ovf_a, if_a.rd_valid_o, if_a.rd_data_o);
        cmp_dut(1, st_b, halt_b, ovf_b, if_b.rd_valid_o, if_b.rd_data_o);
        cmp_dut(2, st_c, halt_c, ovf_c, if_c.rd_valid_o, if_c.rd_data_o);
    endtask

    task automatic rd_const(input string nm, input int idx,
                            input longint unsigned ea, input longint unsigned eb, input longint unsigned ec);
        rd_req = 1'b1;
        rd_idx = idx[2:0];
        tick();
        rd_req = 1'b0;
        chk({nm, " vld"}, if_a.rd_valid_o, 1);
        chk({nm, " a"}, if_a.rd_data_o, ea);
        chk({nm, " b"}, if_b.rd_data_o, eb);
        chk({nm, " c"}, if_c.rd_data_o, ec);
    endtask

    typedef struct {
        int              idx;
        longint unsigned ea, eb, ec;
    } rd_vec_t;

    rd_vec_t tbl [6];
    int      pat [9];

    initial begin
        tbl[0] = '{0, 30, 35, 35};
        tbl[1] = '{1, 30,  1, 35};
        tbl[2] = '{2, 15, 18, 18};
        tbl[3] = '{3,  0,  0,  0};
        tbl[4] = '{5,  0,  0,  0};
        tbl[5] = '{0, 30, 35, 35};
        pat    = '{1, 1, 1, 0, 0, 1, 1, 1, 1};

        rst = 1'b1; start = 1'b0; clear = 1'b0; evt = '0; rd_req = 1'b0; rd_idx = '0;
        tick();
        chk("reset state", st_a, 0);
        chk("reset ovf", ovf_c, 0);
        chk("reset halt", halt_a, 0);
        chk("reset rd_valid", if_b.rd_valid_o, 0);

        // Cycle limit on A; B and C keep running unlimited.
        rst = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 35; i++) begin
            evt = {2'b00, (i % 2 == 0), 1'b1};
            tick();
            if (i == 29) begin
                chk("limit state", st_a, 3);
                chk("limit halt", halt_a, 1);
            end
        end
        start = 1'b0; evt = '0;
        foreach (tbl[i]) rd_const($sformatf("limit rd%0d", i), tbl[i].idx, tbl[i].ea, tbl[i].eb, tbl[i].ec);
        chk("done held", st_a, 3);
        chk("unlimited paused", st_b, 2);

        // Edge versus level counting of a bursty channel.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear state", st_a, 0);
        start = 1'b1; tick();
        foreach (pat[i]) begin
            evt = {3'b000, pat[i] == 1};
            tick();
        end
        start = 1'b0; evt = '0; tick();
        rd_const("edge ch0", 1, 7, 2, 7);
        rd_const("edge cyc", 0, 9, 9, 9);

        // Pause and resume with a held level event.
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; evt = 4'b0010; tick();
        repeat (10) tick();
        start = 1'b0; tick();
        chk("pause state", st_a, 2);
        rd_const("pause cyc", 0, 10, 10, 10);
        rd_const("pause ch1", 2, 10, 10, 10);
        tick(); tick();
        chk("pause still", st_c, 2);
        start = 1'b1; tick();
        repeat (5) tick();
        start = 1'b0; tick();
        rd_const("resume cyc", 0, 15, 15, 15);
        rd_const("resume ch1", 2, 15, 15, 15);

        // Saturation of the narrow instance.
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; evt = 4'b0100; tick();
        repeat (300) tick();
        start = 1'b0; evt = '0; tick();
        chk("sat ovf c", ovf_c, 5'b01001);
        chk("sat ovf b", ovf_b, 0);
        rd_const("sat ch2", 3, 30, 300, 255);
        rd_const("sat cyc", 0, 30, 300, 255);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("sat clear ovf", ovf_c, 0);
        chk("sat clear state", st_c, 0);
        rd_const("sat clear ch2", 3, 0, 0, 0);

        // Back-to-back reads, the last one coincident with clear and out of range.
        start = 1'b1; evt = 4'b0010; tick();
        repeat (4) tick();
        rd_req = 1'b1; rd_idx = 3'd0; tick();
        chk("b2b0 vld", if_a.rd_valid_o, 1);
        chk("b2b0 dat", if_a.rd_data_o, 4);
        rd_idx = 3'd2; tick();
        chk("b2b1 vld", if_b.rd_valid_o, 1);
        chk("b2b1 dat", if_b.rd_data_o, 5);
        rd_idx = 3'd7; clear = 1'b1; tick();
        chk("b2b2 vld", if_c.rd_valid_o, 1);
        chk("b2b2 dat", if_c.rd_data_o, 0);
        rd_req = 1'b0; clear = 1'b0; tick();
        chk("b2b idle vld", if_a.rd_valid_o, 0);

        // Reset in the middle of a run.
        start = 1'b1; evt = 4'b0011; tick();
        repeat (7) tick();
        rst = 1'b1; tick();
        rst = 1'b0; start = 1'b0; evt = '0;
        chk("mid rst state", st_a, 0);
        chk("mid rst ovf", ovf_a, 0);
        chk("mid rst halt", halt_a, 0);
        rd_const("mid rst cyc", 0, 0, 0, 0);
        rd_const("mid rst ch0", 1, 0, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 9) != 0);
            evt    = NE'($urandom);
            rd_req = ($urandom_range(0, 2) != 0);
            rd_idx = 3'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
